mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the 2x256-word load/store memory block.
//  Holds op_code/rwaddr/wdata stable for the block's full multi-cycle pipeline.
//  Drives its stall input and returns load data plus a one-cycle done strobe.
//  Port A = instruction fetch side, port B = load/store unit; round-robin shared.
// PARAMETERS
//  ACC_CYCLES  4   cycles command held on memory bus (memory block read pipe = 3 regs + 1 margin); legal 2..15
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  rst        in   1   asynchronous, active-high reset
//  a_req      in   1   port A request; held high until a_gnt seen
//  a_op       in   3   port A op: 000 LB, 001 LH, 010 LW, 100 SB, 101 SH, 111 SW
//  a_addr     in   11  port A byte address (bit10 = bank select)
//  a_wdata    in   32  port A store data (low byte/half used for SB/SH)
//  a_gnt      out  1   one-cycle pulse: port A command accepted
//  a_done     out  1   one-cycle pulse: port A access complete
//  a_rdata    out  32  port A load result, valid while a_done=1, held afterwards
//  b_*        --   --  identical set for port B (b_req, b_op, b_addr, b_wdata, b_gnt, b_done, b_rdata)
//  m_op_code  out  3   to memory op_code
//  m_rwaddr   out  11  to memory rwaddr
//  m_wdata    out  32  to memory wdata
//  m_stall    out  1   to memory stall; 1 = no write
//  m_rdata    in   32  from memory rdata
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; all gnt/done = 0; a_rdata = b_rdata = 0; m_op_code = 3'b011 (NOP);
//   m_rwaddr = 0; m_wdata = 0; m_stall = 1; round-robin pointer favours A.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: m_stall=1, m_op_code=NOP.
//   At a clock edge with any req=1, pick winner, latch its op/addr/wdata, load counter=ACC_CYCLES-1, go BUSY.
//  Arbitration: one req high -> that port.
//   Both high -> port not granted last; pointer flips to winner on every grant.
//  BUSY: gnt of winner =1 in the first BUSY cycle only.
//   m_op_code/m_rwaddr/m_wdata = latched command, constant for all ACC_CYCLES cycles.
//   m_stall=0; counter decrements each cycle; at counter==0 go DONE.
//   For a load, m_rdata sampled at the edge leaving BUSY into winner's rdata register.
//  DONE: winner done=1 for one cycle.
//   m_stall=1, m_op_code=NOP; go IDLE; req ignored.
//  Latency: req sampled at edge T -> gnt cycle T+1 -> done cycle T+ACC_CYCLES+1.
//   Next arbitration edge at T+ACC_CYCLES+2 (one access per ACC_CYCLES+2 cycles max).
//  Requester must drop req by the cycle after gnt; req still high in IDLE = new request.
//  Store: port rdata unchanged. Load: rdata = m_rdata as sign-extended by memory block.
//  Illegal op (011, 110): gnt given, no BUSY.
//   m_stall stays 1, m_op_code stays NOP, done next cycle, rdata unchanged, pointer still flips.
//  req/op/addr/wdata changes after gnt have no effect on the in-flight access.
//  Reset mid-access: immediate return to reset values.
//   No gnt/done emitted; memory contents at that address undefined for an interrupted store.
// TESTING
//  1 Reset, A LW addr 0x004 after SW 0x004 data 0xDEADBEEF -> a_gnt at T+1, a_done at T+5, a_rdata=0xDEADBEEF.
//  2 A and B req same edge after reset -> A granted; B granted at T+6.
//    With both reqs held continuously, grants alternate A,B,A.
//  3 B SB addr 0x405 data 0x000000F0, then LB 0x405 -> b_rdata=0xFFFFFFF0.
//    m_rwaddr[10]=1 held 4 cycles each access.
//  4 A op=011 -> a_gnt then a_done next cycle, m_stall never 0, a_rdata unchanged.
//  5 rst asserted during 3rd BUSY cycle of B SW -> outputs to reset values same cycle.
//    No b_done; after release A request served normally with A priority.
//  6 A changes a_addr/a_wdata right after a_gnt -> m_rwaddr/m_wdata stay at latched values until DONE.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//   Round-robin arbiter/sequencer between two requesters (A = instruction
//   fetch, B = load/store unit) in front of the 2x256-word load/store memory.
//   A granted command is held unchanged on the memory bus for ACC_CYCLES
//   cycles. This covers the memory's read pipeline. The requester then gets
//   a one-cycle done strobe and, for loads, the returned data.
//
// Ports
//   clk_i, rst_i                   clock, async active-high reset
//   {a,b}_req_i                    request, held until grant seen
//   {a,b}_op_i      [2:0]          000 LB, 001 LH, 010 LW, 100 SB, 101 SH, 111 SW
//   {a,b}_addr_i    [10:0]         byte address, bit 10 = bank select
//   {a,b}_wdata_i   [31:0]         store data
//   {a,b}_gnt_o                    one-cycle pulse: command accepted
//   {a,b}_done_o                   one-cycle pulse: access complete
//   {a,b}_rdata_o   [31:0]         last load result, held
//   m_op_code_o     [2:0]          memory op code (NOP = 011 when idle)
//   m_rwaddr_o      [10:0]         memory address
//   m_wdata_o       [31:0]         memory write data
//   m_stall_o                      memory stall, 1 = no write
//   m_rdata_i       [31:0]         memory read data (already sign-extended)
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int ACC_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic [2:0]  a_op_i,
  input  logic [10:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic        a_gnt_o,
  output logic        a_done_o,
  output logic [31:0] a_rdata_o,
  input  logic        b_req_i,
  input  logic [2:0]  b_op_i,
  input  logic [10:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic        b_gnt_o,
  output logic        b_done_o,
  output logic [31:0] b_rdata_o,
  output logic [2:0]  m_op_code_o,
  output logic [10:0] m_rwaddr_o,
  output logic [31:0] m_wdata_o,
  output logic        m_stall_o,
  input  logic [31:0] m_rdata_i
);

  // ILLG is the grant cycle of an illegal op: no bus activity, done follows.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ILLG = 2'd3;

  localparam logic [2:0] OP_NOP   = 3'b011;
  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        win_b_q, win_b_d;      // current winner: 0 = A, 1 = B
  logic        last_b_q, last_b_d;    // last grant went to B (reset: favour A)
  logic [2:0]  op_q, op_d;
  logic [10:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;

  logic        pick_b;
  logic [2:0]  sel_op;
  logic        sel_illegal;
  logic        gnt_cyc;

  // On a tie the port that was not granted last wins.
  assign pick_b      = b_req_i & (~a_req_i | ~last_b_q);
  assign sel_op      = pick_b ? b_op_i : a_op_i;
  assign sel_illegal = (sel_op == 3'b011) || (sel_op == 3'b110);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_b_d   = win_b_q;
    last_b_d  = last_b_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (a_req_i || b_req_i) begin
          win_b_d  = pick_b;
          last_b_d = pick_b;
          cnt_d    = CNT_LOAD;
          if (sel_illegal) begin
            state_d = S_ILLG;
          end else begin
            state_d = S_BUSY;
            op_d    = sel_op;
            addr_d  = pick_b ? b_addr_i  : a_addr_i;
            wdata_d = pick_b ? b_wdata_i : a_wdata_i;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          // op bit 2 clear = load; data is valid at the final bus cycle
          if (!op_q[2]) begin
            if (win_b_q) b_rdata_d = m_rdata_i;
            else         a_rdata_d = m_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ILLG:  state_d = S_DONE;
      default: state_d = S_IDLE;   // S_DONE
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      win_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      op_q      <= OP_NOP;
      addr_q    <= 11'd0;
      wdata_q   <= 32'd0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_b_q   <= win_b_d;
      last_b_q  <= last_b_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // The counter is still at its load value only in the first BUSY cycle.
  assign gnt_cyc = ((state_q == S_BUSY) && (cnt_q == CNT_LOAD)) || (state_q == S_ILLG);

  assign a_gnt_o   = gnt_cyc & ~win_b_q;
  assign b_gnt_o   = gnt_cyc &  win_b_q;
  assign a_done_o  = (state_q == S_DONE) & ~win_b_q;
  assign b_done_o  = (state_q == S_DONE) &  win_b_q;
  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

  assign m_stall_o   = (state_q != S_BUSY);
  assign m_op_code_o = (state_q == S_BUSY) ? op_q : OP_NOP;
  assign m_rwaddr_o  = addr_q;
  assign m_wdata_o   = wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  localparam logic [2:0] LB = 3'b000, LW = 3'b010, SB = 3'b100, SW = 3'b111;
  localparam logic [2:0] NOP = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req;
  logic [2:0]  a_op, b_op;
  logic [10:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic [2:0]  m_op_code;
  logic [10:0] m_rwaddr;
  logic [31:0] m_wdata;
  logic        m_stall;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ACC_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_op_i(a_op), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_done_o(a_done), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_op_i(b_op), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_done_o(b_done), .b_rdata_o(b_rdata),
    .m_op_code_o(m_op_code), .m_rwaddr_o(m_rwaddr), .m_wdata_o(m_wdata),
    .m_stall_o(m_stall), .m_rdata_i(m_rdata)
  );

  // Byte-addressed memory model: 3-register read pipe, sign-extending loads.
  logic [7:0]  mem [0:2047];
  logic        mem_clr = 1'b1;
  logic [31:0] rd_val, rd_s1, rd_s2, rd_s3;
  logic [10:0] wa, ha;

  always_comb begin
    wa = {m_rwaddr[10:2], 2'b00};
    ha = {m_rwaddr[10:1], 1'b0};
    rd_val = 32'd0;
    case (m_op_code)
      3'b000:  rd_val = {{24{mem[m_rwaddr][7]}}, mem[m_rwaddr]};
      3'b001:  rd_val = {{16{mem[ha+11'd1][7]}}, mem[ha+11'd1], mem[ha]};
      3'b010:  rd_val = {mem[wa+11'd3], mem[wa+11'd2], mem[wa+11'd1], mem[wa]};
      default: rd_val = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    rd_s1 <= rd_val;
    rd_s2 <= rd_s1;
    rd_s3 <= rd_s2;
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
    end else if (!m_stall) begin
      case (m_op_code)
        3'b100: mem[m_rwaddr] <= m_wdata[7:0];
        3'b101: begin
          mem[ha] <= m_wdata[7:0];
          mem[ha+11'd1] <= m_wdata[15:8];
        end
        3'b111: begin
          mem[wa] <= m_wdata[7:0];
          mem[wa+11'd1] <= m_wdata[15:8];
          mem[wa+11'd2] <= m_wdata[23:16];
          mem[wa+11'd3] <= m_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  assign m_rdata = rd_s3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Full legal access on one port, starting at a negedge with the arbiter idle.
  // After the grant the port inputs are scrambled; the bus must not follow.
  task automatic access(input bit pb, input logic [2:0] op, input logic [10:0] addr,
                        input logic [31:0] wd, input bit chk_rd, input logic [31:0] exp_rd);
    if (pb) begin b_req = 1; b_op = op; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1; a_op = op; a_addr = addr; a_wdata = wd; end
    @(negedge clk);
    chk("gnt", pb ? b_gnt : a_gnt, 1);
    chk("other_gnt", pb ? a_gnt : b_gnt, 0);
    chk("stall_busy", m_stall, 0);
    chk("op_bus", m_op_code, op);
    chk("addr_bus", m_rwaddr, addr);
    chk("wdata_bus", m_wdata, wd);
    if (pb) begin b_req = 0; b_op = ~op; b_addr = ~addr; b_wdata = ~wd; end
    else    begin a_req = 0; a_op = ~op; a_addr = ~addr; a_wdata = ~wd; end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_stall", m_stall, 0);
      chk("hold_op", m_op_code, op);
      chk("hold_addr", m_rwaddr, addr);
      chk("hold_wdata", m_wdata, wd);
      chk("hold_gnt", pb ? b_gnt : a_gnt, 0);
      chk("hold_done", pb ? b_done : a_done, 0);
    end
    @(negedge clk);
    chk("done", pb ? b_done : a_done, 1);
    chk("done_stall", m_stall, 1);
    chk("done_op", m_op_code, NOP);
    if (chk_rd) chk("rdata", pb ? b_rdata : a_rdata, exp_rd);
    @(negedge clk);
    chk("done_end", pb ? b_done : a_done, 0);
  endtask

  initial begin
    rst = 1; a_req = 0; b_req = 0; a_op = NOP; b_op = NOP;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    @(negedge clk);
    mem_clr = 0;
    @(negedge clk);
    chk("rst_gnt", {a_gnt, b_gnt, a_done, b_done}, 0);
    chk("rst_rdata_a", a_rdata, 0);
    chk("rst_rdata_b", b_rdata, 0);
    chk("rst_op", m_op_code, NOP);
    chk("rst_stall", m_stall, 1);
    chk("rst_addr", m_rwaddr, 0);
    chk("rst_wdata", m_wdata, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_stall", m_stall, 1);

    // store then load on A
    access(0, SW, 11'h004, 32'hDEADBEEF, 1, 32'h0);
    access(0, LW, 11'h004, 32'h0, 1, 32'hDEADBEEF);
    @(negedge clk);
    chk("a_rdata_held", a_rdata, 32'hDEADBEEF);

    // B byte store / sign-extended byte load in bank 1
    access(1, SB, 11'h405, 32'h000000F0, 1, 32'h0);
    access(1, LB, 11'h405, 32'h0, 1, 32'hFFFFFFF0);

    // illegal op on A: grant, done next cycle, bus stays idle
    a_req = 1; a_op = 3'b011; a_addr = 11'h100;
    @(negedge clk);
    chk("ill_gnt", a_gnt, 1);
    chk("ill_stall0", m_stall, 1);
    chk("ill_op0", m_op_code, NOP);
    a_req = 0;
    @(negedge clk);
    chk("ill_done", a_done, 1);
    chk("ill_stall1", m_stall, 1);
    chk("ill_rdata", a_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("ill_done_end", a_done, 0);

    // pointer flipped to A by the illegal grant: tie now goes to B
    a_req = 1; a_op = LW; a_addr = 11'h004;
    b_req = 1; b_op = LW; b_addr = 11'h405;
    @(negedge clk);
    chk("tie_b_gnt", b_gnt, 1);
    chk("tie_a_gnt", a_gnt, 0);
    a_req = 0; b_req = 0;
    repeat (4) @(negedge clk);
    chk("tie_b_done", b_done, 1);
    chk("tie_b_rdata", b_rdata, 32'h0000F000);
    @(negedge clk);

    // after reset, both held continuously: A (1), B (7), A (13)
    rst = 1;
    @(negedge clk);
    rst = 0;
    a_req = 1; a_op = LW; a_addr = 11'h004;
    b_req = 1; b_op = LW; b_addr = 11'h004;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("rr_a_gnt_%0d", k), a_gnt, (k == 1 || k == 13) ? 1 : 0);
      chk($sformatf("rr_b_gnt_%0d", k), b_gnt, (k == 7) ? 1 : 0);
      chk($sformatf("rr_a_done_%0d", k), a_done, (k == 5) ? 1 : 0);
      chk($sformatf("rr_b_done_%0d", k), b_done, (k == 11) ? 1 : 0);
    end
    a_req = 0; b_req = 0;
    repeat (3) @(negedge clk);
    chk("rr_last_done", a_done, 1);
    chk("rr_b_rdata", b_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // reset during 3rd BUSY cycle of a B store
    b_req = 1; b_op = SW; b_addr = 11'h010; b_wdata = 32'h12345678;
    @(negedge clk);
    chk("mid_gnt", b_gnt, 1);
    b_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", m_stall, 0);
    rst = 1;
    #1;
    chk("mid_rst_stall", m_stall, 1);
    chk("mid_rst_op", m_op_code, NOP);
    chk("mid_rst_addr", m_rwaddr, 0);
    chk("mid_rst_wdata", m_wdata, 0);
    chk("mid_rst_rdata", {a_rdata | b_rdata}, 0);
    chk("mid_rst_pulses", {a_gnt, b_gnt, a_done, b_done}, 0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_pulse", {b_gnt, b_done}, 0);
    end
    a_req = 1; a_op = LW; a_addr = 11'h004;
    b_req = 1; b_op = LW; b_addr = 11'h004;
    @(negedge clk);
    chk("post_a_gnt", a_gnt, 1);
    chk("post_b_gnt", b_gnt, 0);
    a_req = 0; b_req = 0;
    repeat (4) @(negedge clk);
    chk("post_a_done", a_done, 1);
    chk("post_a_rdata", a_rdata, 32'hDEADBEEF);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
